pipe_hazard_ctrl: RTL

Parametrised pipeline flow controller for the 5-stage tinyriscv core. It replaces the separate hazard-detect and stall-control pair with a single block. The block generates per-stage hold and bubble (flush) vectors and operand forwarding selects. It also handles data-memory wait states, keeps a pending jump across memory waits, and provides a memory-wait watchdog and a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline flow controller for the 5-stage tinyriscv core.
// Produces per-stage hold/bubble vectors, operand forwarding selects, a
// deferred jump request across data-memory wait states, a sticky memory-wait
// watchdog flag and a saturating stall-cycle counter.
// Stage index: 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
// Optional feature macro: PIPE_HAZARD_FWD_EN
//   defined   : EX/MEM/WB forwarding; only load-use hazards stall.
//   undefined : forwarding selects tie to 00; any ID match against EX, MEM or
//               WB stalls until the writer has retired.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15,
  parameter int PERF_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_re,
  input  logic                  id_rs2_re,
  input  logic                  ex_reg_we,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
  input  logic                  ex_is_load,
  input  logic                  mem_reg_we,
  input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
  input  logic                  wb_reg_we,
  input  logic [REG_ADDR_W-1:0] wb_reg_waddr,
  input  logic                  jump_flag_i,
  input  logic                  mem_busy_i,
  output logic [4:0]            hold_o,
  output logic [4:0]            bubble_o,
  output logic [1:0]            fwd_sel_rs1_o,
  output logic [1:0]            fwd_sel_rs2_o,
  output logic                  jump_flag_o,
  output logic                  mem_timeout_o,
  output logic [PERF_W-1:0]     stall_cycles_o
);

  // Wait counter is just wide enough to hold MEM_WAIT_MAX and saturates there.
  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  // Control vectors used by the priority resolver.
  localparam logic [4:0] HOLD_ALL    = 5'b11111; // freeze whole pipe on mem wait
  localparam logic [4:0] HOLD_FRONT  = 5'b00011; // freeze PC and IF/ID
  localparam logic [4:0] BUBBLE_EX   = 5'b00100; // NOP into ID/EX
  localparam logic [4:0] BUBBLE_JUMP = 5'b00110; // flush IF/ID and ID/EX

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HAZ_STALL = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  pending_jump_reg, pending_jump_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic                  timeout_reg, timeout_next;
  logic [PERF_W-1:0]     stall_cnt_reg;

  // Writers packed by age: 0 = EX (youngest), 1 = MEM, 2 = WB (oldest).
  logic [2:0]                  wr_we;
  logic [2:0][REG_ADDR_W-1:0]  wr_addr;
  logic [2:0]                  rs1_match;
  logic [2:0]                  rs2_match;

  assign wr_we   = {wb_reg_we, mem_reg_we, ex_reg_we};
  assign wr_addr = {wb_reg_waddr, mem_reg_waddr, ex_reg_waddr};

  // One comparator pair per writer; x0 is hard-wired zero and never matches.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign rs1_match[gi] = id_rs1_re && wr_we[gi] &&
                             (id_rs1 == wr_addr[gi]) && (id_rs1 != '0);
      assign rs2_match[gi] = id_rs2_re && wr_we[gi] &&
                             (id_rs2 == wr_addr[gi]) && (id_rs2 != '0);
    end
  endgenerate

  logic       data_stall;
  logic [1:0] fwd_rs1_raw;
  logic [1:0] fwd_rs2_raw;

`ifdef PIPE_HAZARD_FWD_EN
  // Youngest matching writer wins; a load in EX has no data yet, so it is
  // skipped here and covered by the load-use stall instead.
  always_comb begin
    fwd_rs1_raw = 2'b00;
    if (rs1_match[0] && !ex_is_load) fwd_rs1_raw = 2'b01;
    else if (rs1_match[1])           fwd_rs1_raw = 2'b10;
    else if (rs1_match[2])           fwd_rs1_raw = 2'b11;

    fwd_rs2_raw = 2'b00;
    if (rs2_match[0] && !ex_is_load) fwd_rs2_raw = 2'b01;
    else if (rs2_match[1])           fwd_rs2_raw = 2'b10;
    else if (rs2_match[2])           fwd_rs2_raw = 2'b11;
  end

  // Only a load feeding the very next instruction needs a stall.
  assign data_stall = ex_is_load && (rs1_match[0] || rs2_match[0]);
`else
  // Without forwarding the operand must come from the register file, so any
  // in-flight writer of a source register stalls ID until it has retired.
  assign fwd_rs1_raw = 2'b00;
  assign fwd_rs2_raw = 2'b00;
  assign data_stall  = (|rs1_match) || (|rs2_match);

  // The load flag only matters when forwarding exists.
  logic unused_ex_is_load;
  assign unused_ex_is_load = ex_is_load;
`endif

  logic [4:0] hold_raw;
  logic [4:0] bubble_raw;
  logic       jump_raw;

  // Priority resolver: mem wait > jump (live or deferred) > data hazard > run.
  always_comb begin
    state_next        = ST_RUN;
    hold_raw          = '0;
    bubble_raw        = '0;
    jump_raw          = 1'b0;
    pending_jump_next = pending_jump_reg;
    wait_cnt_next     = '0;
    timeout_next      = timeout_reg;

    if (mem_busy_i) begin
      state_next = ST_MEM_WAIT;
      hold_raw   = HOLD_ALL;
      // A jump resolved while the pipe is frozen is remembered and issued on
      // the first cycle the memory is ready again.
      if (jump_flag_i) pending_jump_next = 1'b1;
      // The count restarts at 1 on the first busy cycle of a wait run.
      if (state_reg != ST_MEM_WAIT) begin
        wait_cnt_next = WAIT_W'(1);
      end else if (wait_cnt_reg == WAIT_LIMIT) begin
        wait_cnt_next = WAIT_LIMIT;
      end else begin
        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
      if (wait_cnt_next == WAIT_LIMIT) timeout_next = 1'b1;
    end else if (jump_flag_i || pending_jump_reg) begin
      // The instruction in ID is flushed, so its hazard is irrelevant.
      state_next        = ST_RUN;
      jump_raw          = 1'b1;
      bubble_raw        = BUBBLE_JUMP;
      pending_jump_next = 1'b0;
    end else if (data_stall) begin
      state_next = ST_HAZ_STALL;
      hold_raw   = HOLD_FRONT;
      bubble_raw = BUBBLE_EX;
    end
  end

  // Everything combinational reads as zero while reset is asserted.
  assign hold_o        = rst ? 5'b0 : hold_raw;
  assign bubble_o      = rst ? 5'b0 : bubble_raw;
  assign jump_flag_o   = rst ? 1'b0 : jump_raw;
  assign fwd_sel_rs1_o = rst ? 2'b00 : fwd_rs1_raw;
  assign fwd_sel_rs2_o = rst ? 2'b00 : fwd_rs2_raw;

  // Controller state, deferred jump, wait counter and sticky watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      pending_jump_reg <= 1'b0;
      wait_cnt_reg     <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pending_jump_reg <= pending_jump_next;
      wait_cnt_reg     <= wait_cnt_next;
      timeout_reg      <= timeout_next;
    end
  end

  // Saturating count of cycles in which any stage is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((hold_o != 5'b0) && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
    end
  end

  assign mem_timeout_o  = timeout_reg;
  assign stall_cycles_o = stall_cnt_reg;

endmodule
